// File: rtl/gg_nal_byte_packer.sv
// Annex-B byte packer: strips emulation-prevention bytes and packs the remaining
// stream bytes MSB-first into WID-bit words, exposing a 4-byte look-ahead on out_pad.
module gg_nal_byte_packer #(
    parameter int WID = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WID-1:0]   out_bits,
    output logic [31:0]      out_pad,
    output logic [WID/8-1:0] out_nal_start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      epb_count,
    output logic [1:0]       dbg_state
);
    localparam int BYTE_WID = WID / 8;
    localparam int NB       = BYTE_WID + 4;
    localparam int FILL_W   = $clog2(NB + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NB);
    localparam logic [FILL_W-1:0] FILL_WORD = FILL_W'(BYTE_WID);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        mem_q [NB];
    logic [7:0]        mem_d [NB];
    logic [FILL_W-1:0] fill_q, fill_d, base;
    logic [1:0]        zrun_q, zrun_d;
    logic              first_q, first_d;
    logic [15:0]       epb_q, epb_d;
    logic              accept, drop, store, consume;

    // Handshakes: a byte moves on in_valid&in_ready, a word on out_valid&out_ready,
    // both sampled at the rising clock edge; neither ready depends on its own valid.
    assign accept  = in_valid & in_ready;
    assign drop    = accept & (in_byte == 8'h03) & (zrun_q == 2'd2);
    assign store   = accept & ~drop;
    assign consume = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = in_last ? S_FLUSH : S_FILL;
            S_FILL:  if (accept && in_last) state_d = S_FLUSH;
            S_FLUSH: if (fill_d == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // in_ready is forced low during reset so nothing is accepted while clearing.
    always_comb begin
        in_ready      = ~reset & (state_q != S_FLUSH) & (fill_q < FILL_FULL);
        out_valid     = (fill_q == FILL_FULL) | ((state_q == S_FLUSH) & (fill_q != '0));
        out_nal_start = '0;
        out_nal_start[BYTE_WID-1] = first_q & out_valid;
        out_bits      = '0;
        out_pad       = '0;
        for (int i = 0; i < BYTE_WID; i++) begin
            if (FILL_W'(i) < fill_q) out_bits[WID-1-8*i -: 8] = mem_q[i];
        end
        for (int j = 0; j < 4; j++) begin
            if (FILL_W'(BYTE_WID + j) < fill_q) out_pad[31-8*j -: 8] = mem_q[BYTE_WID+j];
        end
        dbg_state = state_q;
        epb_count = epb_q;
    end

    // On consume the 4 look-ahead bytes slide to the front; a byte arriving in the
    // same cycle lands just after whatever survives the shift.
    always_comb begin
        for (int i = 0; i < NB; i++) mem_d[i] = mem_q[i];
        base = fill_q;
        if (consume) begin
            for (int i = 0; i < 4; i++) mem_d[i] = mem_q[i+BYTE_WID];
            for (int i = 4; i < NB; i++) mem_d[i] = 8'h00;
            base = (fill_q > FILL_WORD) ? fill_q - FILL_WORD : '0;
        end
        if (store) mem_d[base] = in_byte;
        fill_d = base + {{(FILL_W-1){1'b0}}, store};

        zrun_d = zrun_q;
        if ((state_q == S_FLUSH) && (fill_d == '0)) begin
            zrun_d = 2'd0;
        end else if (accept) begin
            if (!drop && (in_byte == 8'h00)) zrun_d = (zrun_q == 2'd2) ? 2'd2 : zrun_q + 2'd1;
            else zrun_d = 2'd0;
        end

        first_d = first_q;
        if (consume) first_d = 1'b0;
        else if ((state_q == S_IDLE) && accept) first_d = 1'b1;

        epb_d = epb_q;
        if (drop && (epb_q != 16'hFFFF)) epb_d = epb_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NB; i++) mem_q[i] <= 8'h00;
            fill_q  <= '0;
            zrun_q  <= 2'd0;
            first_q <= 1'b0;
            epb_q   <= 16'd0;
        end else begin
            for (int i = 0; i < NB; i++) mem_q[i] <= mem_d[i];
            fill_q  <= fill_d;
            zrun_q  <= zrun_d;
            first_q <= first_d;
            epb_q   <= epb_d;
        end
    end

endmodule
